// File: rtl/pim_input_frame_buffer_if.sv
// ---------------------------------------------------------------------------
// pim_input_frame_buffer_if
//
// Groups the write, control, driver and status signals of the PIM input frame
// buffer. The _i/_o suffixes are from the buffer's point of view.
//
// Modports:
//   slave  - the frame buffer itself (takes *_i, produces *_o)
//   master - the surrounding peri controller / column driver side
//
// Signals:
//   wr_valid_i, wr_data_i[31:0], wr_ready_o     : word write handshake
//   flush_i                                     : commit the partial frame
//   clear_i                                     : soft clear of control state
//   drv_valid_o, drv_data_o[FRAME_W-1:0]        : head frame to column driver
//   drv_release_i                               : driver done with head frame
//   fill_cnt_o, occupancy_o, frame_cnt_o,
//   ovf_err_o                                   : status
// ---------------------------------------------------------------------------
interface pim_input_frame_buffer_if #(
   parameter int NUM_COL  = 256,
   parameter int ELEM_W   = 2,
   parameter int NUM_BANK = 2
);
   localparam int FRAME_W = NUM_COL * ELEM_W;
   localparam int WORDS   = FRAME_W / 32;
   localparam int WC_W    = $clog2(WORDS) + 1;
   localparam int OC_W    = $clog2(NUM_BANK) + 1;

   logic               wr_valid_i;
   logic [31:0]        wr_data_i;
   logic               wr_ready_o;
   logic               flush_i;
   logic               clear_i;
   logic               drv_valid_o;
   logic [FRAME_W-1:0] drv_data_o;
   logic               drv_release_i;
   logic [WC_W-1:0]    fill_cnt_o;
   logic [OC_W-1:0]    occupancy_o;
   logic [15:0]        frame_cnt_o;
   logic               ovf_err_o;

   modport slave (
      input  wr_valid_i, wr_data_i, flush_i, clear_i, drv_release_i,
      output wr_ready_o, drv_valid_o, drv_data_o, fill_cnt_o, occupancy_o,
             frame_cnt_o, ovf_err_o
   );

   modport master (
      output wr_valid_i, wr_data_i, flush_i, clear_i, drv_release_i,
      input  wr_ready_o, drv_valid_o, drv_data_o, fill_cnt_o, occupancy_o,
             frame_cnt_o, ovf_err_o
   );
endinterface

// File: rtl/pim_input_frame_buffer.sv
// ---------------------------------------------------------------------------
// pim_input_frame_buffer
//
// Packs 32-bit words into NUM_COL x ELEM_W-bit column-input frames and queues
// them in a ring of NUM_BANK banks, so a new frame can be filled while the
// column driver consumes the head frame.
//
// Ports:
//   clk_i   - clock, rising edge
//   rst_ni  - synchronous active-low reset (clears control state and banks)
//   bus     - pim_input_frame_buffer_if.slave (write handshake, flush, clear,
//             driver handshake, fill count, occupancy, frame count, overflow)
//
// Optional feature:
//   PIM_INBUF_FLUSH_EN - when defined, flush_i commits a partial frame with
//                        its unwritten words zeroed. When undefined, flush_i
//                        is ignored.
// ---------------------------------------------------------------------------
module pim_input_frame_buffer #(
   parameter int NUM_COL  = 256,
   parameter int ELEM_W   = 2,
   parameter int NUM_BANK = 2
) (
   input logic                     clk_i,
   input logic                     rst_ni,
   pim_input_frame_buffer_if.slave bus
);
   localparam int FRAME_W = NUM_COL * ELEM_W;
   localparam int WORDS   = FRAME_W / 32;
   localparam int WC_W    = $clog2(WORDS) + 1;
   localparam int OC_W    = $clog2(NUM_BANK) + 1;
   localparam int PTR_W   = $clog2(NUM_BANK);

   localparam logic [OC_W-1:0] OCC_FULL  = OC_W'(NUM_BANK);
   localparam logic [WC_W-1:0] LAST_WORD = WC_W'(WORDS - 1);

   logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
   logic [WC_W-1:0]    fill_cnt_q, fill_cnt_d;
   logic [OC_W-1:0]    occupancy_q, occupancy_d;
   logic [15:0]        frame_cnt_q, frame_cnt_d;
   logic               ovf_err_q, ovf_err_d;
   logic [FRAME_W-1:0] bank_q [NUM_BANK];
   logic [FRAME_W-1:0] bank_d [NUM_BANK];

   logic            wr_ready;
   logic            drv_valid;
   logic            accept;
   logic            release_go;
   logic            complete;
   logic            flush_go;
   logic [WC_W-1:0] fill_after;

`ifndef PIM_INBUF_FLUSH_EN
   logic unused_flush;
   assign unused_flush = bus.flush_i;
`endif

   // Ready and valid come straight from registered occupancy; a release in a
   // full cycle only frees the slot from the next cycle on.
   assign wr_ready = (occupancy_q < OCC_FULL);
   assign drv_valid = (occupancy_q != '0);

   assign bus.wr_ready_o  = wr_ready;
   assign bus.drv_valid_o = drv_valid;
   assign bus.drv_data_o  = bank_q[rd_ptr_q];
   assign bus.fill_cnt_o  = fill_cnt_q;
   assign bus.occupancy_o = occupancy_q;
   assign bus.frame_cnt_o = frame_cnt_q;
   assign bus.ovf_err_o   = ovf_err_q;

   // Next-state logic: word packing, frame commit, head release, flush and
   // overflow detection. clear_i overrides everything except bank contents.
   always_comb begin
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      fill_cnt_d  = fill_cnt_q;
      occupancy_d = occupancy_q;
      frame_cnt_d = frame_cnt_q;
      ovf_err_d   = ovf_err_q;
      bank_d      = bank_q;

      accept     = bus.wr_valid_i && wr_ready;
      release_go = bus.drv_release_i && drv_valid;
      complete   = accept && (fill_cnt_q == LAST_WORD);
      fill_after = fill_cnt_q + WC_W'(accept);

`ifdef PIM_INBUF_FLUSH_EN
      flush_go = bus.flush_i && (fill_after != '0) && wr_ready && !complete;
`else
      flush_go = 1'b0;
`endif

      if (bus.clear_i) begin
         wr_ptr_d    = '0;
         rd_ptr_d    = '0;
         fill_cnt_d  = '0;
         occupancy_d = '0;
         frame_cnt_d = '0;
         ovf_err_d   = 1'b0;
      end else begin
         if (bus.wr_valid_i && !wr_ready) begin
            ovf_err_d = 1'b1;
         end

         // The fill bank is never a queued bank, so these writes cannot
         // disturb the frame the driver is reading.
         for (int w = 0; w < WORDS; w++) begin
            if (accept && (WC_W'(w) == fill_cnt_q)) begin
               bank_d[wr_ptr_q][32*w +: 32] = bus.wr_data_i;
            end
            if (flush_go && (WC_W'(w) >= fill_after)) begin
               bank_d[wr_ptr_q][32*w +: 32] = '0;
            end
         end

         if (accept) begin
            fill_cnt_d = fill_after;
         end

         if (complete || flush_go) begin
            fill_cnt_d = '0;
            wr_ptr_d   = wr_ptr_q + PTR_W'(1);
         end

         if (release_go) begin
            rd_ptr_d    = rd_ptr_q + PTR_W'(1);
            frame_cnt_d = frame_cnt_q + 16'd1;
         end

         // Commit and release together leave occupancy unchanged.
         if ((complete || flush_go) && !release_go) begin
            occupancy_d = occupancy_q + OC_W'(1);
         end else if (!(complete || flush_go) && release_go) begin
            occupancy_d = occupancy_q - OC_W'(1);
         end
      end
   end

   // State register; reset also wipes bank storage so drv_data_o reads zero.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         fill_cnt_q  <= '0;
         occupancy_q <= '0;
         frame_cnt_q <= '0;
         ovf_err_q   <= 1'b0;
         for (int b = 0; b < NUM_BANK; b++) begin
            bank_q[b] <= '0;
         end
      end else begin
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         fill_cnt_q  <= fill_cnt_d;
         occupancy_q <= occupancy_d;
         frame_cnt_q <= frame_cnt_d;
         ovf_err_q   <= ovf_err_d;
         for (int b = 0; b < NUM_BANK; b++) begin
            bank_q[b] <= bank_d[b];
         end
      end
   end
endmodule

// File: tb/tb_pim_input_frame_buffer.sv
// ---------------------------------------------------------------------------
// tb_pim_input_frame_buffer
//
// Self-checking bench for pim_input_frame_buffer with default parameters.
// The reference model keeps the partial frame as a queue of words and the
// committed frames as a queue of full frame vectors. Honours
// PIM_INBUF_FLUSH_EN the same way as the design.
// ---------------------------------------------------------------------------
module tb_pim_input_frame_buffer;
   localparam int NUM_COL  = 256;
   localparam int ELEM_W   = 2;
   localparam int NUM_BANK = 2;
   localparam int FRAME_W  = NUM_COL * ELEM_W;
   localparam int WORDS    = FRAME_W / 32;

   logic clk = 1'b0;
   logic rst_ni = 1'b0;

   pim_input_frame_buffer_if #(
      .NUM_COL(NUM_COL), .ELEM_W(ELEM_W), .NUM_BANK(NUM_BANK)
   ) bus ();

   pim_input_frame_buffer #(
      .NUM_COL(NUM_COL), .ELEM_W(ELEM_W), .NUM_BANK(NUM_BANK)
   ) dut (
      .clk_i (clk),
      .rst_ni(rst_ni),
      .bus   (bus.slave)
   );

   always #5 clk = ~clk;

   int assert_cnt = 0;
   int fail_cnt   = 0;

   logic [31:0]        m_partial [$];
   logic [FRAME_W-1:0] m_fifo [$];
   logic [15:0]        m_frame_cnt;
   logic               m_ovf;

   task automatic checkOutput(input string tag, input logic [FRAME_W-1:0] observed,
                              input logic [FRAME_W-1:0] expected);
      assert_cnt++;
      if (observed !== expected) begin
         fail_cnt++;
         $display("[TB] FAIL %s: observed 0x%0h required 0x%0h", tag, observed, expected);
      end
   endtask

   task automatic modelClear();
      m_partial.delete();
      m_fifo.delete();
      m_frame_cnt = '0;
      m_ovf = 1'b0;
   endtask

   task automatic modelStep(input logic v, input logic [31:0] d, input logic rel,
                            input logic clr, input logic fl);
      int                 pre_size;
      logic               ready;
      logic               do_rel;
      logic               completed;
      logic [FRAME_W-1:0] frame;
      pre_size  = m_fifo.size();
      ready     = (pre_size < NUM_BANK);
      do_rel    = rel && (pre_size != 0);
      completed = 1'b0;
      frame     = '0;
      if (clr) begin
         modelClear();
         return;
      end
      if (v && !ready) m_ovf = 1'b1;
      if (v && ready) begin
         m_partial.push_back(d);
         if (m_partial.size() == WORDS) begin
            for (int i = 0; i < WORDS; i++) frame[32*i +: 32] = m_partial[i];
            m_partial.delete();
            completed = 1'b1;
         end
      end
`ifdef PIM_INBUF_FLUSH_EN
      if (fl && ready && !completed && (m_partial.size() != 0)) begin
         for (int i = 0; i < m_partial.size(); i++) frame[32*i +: 32] = m_partial[i];
         m_partial.delete();
         completed = 1'b1;
      end
`else
      if (fl) frame = frame;
`endif
      if (do_rel) begin
         void'(m_fifo.pop_front());
         m_frame_cnt = m_frame_cnt + 16'd1;
      end
      if (completed) m_fifo.push_back(frame);
   endtask

   task automatic checkAll(input string tag);
      checkOutput({tag, ".wr_ready"}, bus.wr_ready_o, m_fifo.size() < NUM_BANK);
      checkOutput({tag, ".drv_valid"}, bus.drv_valid_o, m_fifo.size() != 0);
      checkOutput({tag, ".fill_cnt"}, bus.fill_cnt_o, m_partial.size());
      checkOutput({tag, ".occupancy"}, bus.occupancy_o, m_fifo.size());
      checkOutput({tag, ".frame_cnt"}, bus.frame_cnt_o, m_frame_cnt);
      checkOutput({tag, ".ovf_err"}, bus.ovf_err_o, m_ovf);
      if (m_fifo.size() != 0) checkOutput({tag, ".drv_data"}, bus.drv_data_o, m_fifo[0]);
   endtask

   // Inputs change on the falling edge; outputs are compared on the next
   // falling edge, after the rising edge that consumed the inputs.
   task automatic applyStimulus(input string tag, input logic v, input logic [31:0] d,
                                input logic rel, input logic clr, input logic fl);
      bus.wr_valid_i    = v;
      bus.wr_data_i     = d;
      bus.drv_release_i = rel;
      bus.clear_i       = clr;
      bus.flush_i       = fl;
      @(posedge clk);
      modelStep(v, d, rel, clr, fl);
      @(negedge clk);
      bus.wr_valid_i    = 1'b0;
      bus.drv_release_i = 1'b0;
      bus.clear_i       = 1'b0;
      bus.flush_i       = 1'b0;
      checkAll(tag);
   endtask

   task automatic doReset(input string tag);
      rst_ni = 1'b0;
      @(posedge clk);
      modelClear();
      @(negedge clk);
      rst_ni = 1'b1;
      checkAll(tag);
      checkOutput({tag, ".drv_data_zero"}, bus.drv_data_o, '0);
   endtask

   initial begin
      bus.wr_valid_i    = 1'b0;
      bus.wr_data_i     = '0;
      bus.drv_release_i = 1'b0;
      bus.clear_i       = 1'b0;
      bus.flush_i       = 1'b0;
      modelClear();
      @(negedge clk);
      doReset("reset");

      // Full frame of words 0..15
      for (int i = 0; i < WORDS; i++) applyStimulus("fill0", 1'b1, 32'(i), 1'b0, 1'b0, 1'b0);
      checkOutput("full.valid", bus.drv_valid_o, 1'b1);
      checkOutput("full.lo", bus.drv_data_o[31:0], 32'h0);
      checkOutput("full.hi", bus.drv_data_o[FRAME_W-1 -: 32], 32'hF);
      checkOutput("full.occ", bus.occupancy_o, 1);
      checkOutput("full.fill", bus.fill_cnt_o, 0);

      // Second frame, then overflow while full
      for (int i = 0; i < WORDS; i++) applyStimulus("fill1", 1'b1, $urandom, 1'b0, 1'b0, 1'b0);
      checkOutput("bp.occ", bus.occupancy_o, 2);
      checkOutput("bp.ready", bus.wr_ready_o, 1'b0);
      applyStimulus("ovf", 1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0, 1'b0);
      checkOutput("ovf.err", bus.ovf_err_o, 1'b1);

      // Release from full
      applyStimulus("rel", 1'b0, '0, 1'b1, 1'b0, 1'b0);
      checkOutput("rel.ready", bus.wr_ready_o, 1'b1);
      checkOutput("rel.fcnt", bus.frame_cnt_o, 1);
      checkOutput("rel.occ", bus.occupancy_o, 1);

      // Completion coincident with release at occupancy 1
      for (int i = 0; i < WORDS - 1; i++) applyStimulus("sim", 1'b1, $urandom, 1'b0, 1'b0, 1'b0);
      applyStimulus("sim.last", 1'b1, 32'h1234_5678, 1'b1, 1'b0, 1'b0);
      checkOutput("sim.occ", bus.occupancy_o, 1);
      checkOutput("sim.word", bus.drv_data_o[FRAME_W-1 -: 32], 32'h1234_5678);

      // Clear mid-frame, then a clean frame, then reset zeroes the output
      for (int i = 0; i < 5; i++) applyStimulus("pre_clr", 1'b1, $urandom, 1'b0, 1'b0, 1'b0);
      applyStimulus("clr", 1'b0, '0, 1'b0, 1'b1, 1'b0);
      checkOutput("clr.fill", bus.fill_cnt_o, 0);
      checkOutput("clr.valid", bus.drv_valid_o, 1'b0);
      checkOutput("clr.ovf", bus.ovf_err_o, 1'b0);
      for (int i = 0; i < WORDS; i++) applyStimulus("post_clr", 1'b1, 32'hC000_0000 | 32'(i), 1'b0, 1'b0, 1'b0);
      checkOutput("post_clr.lo", bus.drv_data_o[31:0], 32'hC000_0000);
      doReset("reset2");

      // Flush of a 3-word partial frame
      for (int i = 0; i < 3; i++) applyStimulus("pre_fl", 1'b1, 32'hAAAA_AAAA, 1'b0, 1'b0, 1'b0);
      applyStimulus("flush", 1'b0, '0, 1'b0, 1'b0, 1'b1);
`ifdef PIM_INBUF_FLUSH_EN
      checkOutput("flush.valid", bus.drv_valid_o, 1'b1);
      checkOutput("flush.lo", bus.drv_data_o[95:0], {3{32'hAAAA_AAAA}});
      checkOutput("flush.hi", bus.drv_data_o[FRAME_W-1:96], '0);
`else
      checkOutput("flush.valid", bus.drv_valid_o, 1'b0);
      checkOutput("flush.fill", bus.fill_cnt_o, 3);
`endif

      // Randomized traffic against the model
      doReset("reset3");
      for (int c = 0; c < 3000; c++) begin
         applyStimulus("rand",
                       $urandom_range(0, 9) < 7,
                       $urandom,
                       $urandom_range(0, 9) < 4,
                       $urandom_range(0, 199) == 0,
                       $urandom_range(0, 19) == 0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
      $finish;
   end
endmodule
